gcd_controller: RTL
===================

// Module: gcd_controller
// PURPOSE
//  FSM that sequences the 4-bit subtractive GCD datapath (x/y/d regs, subtractors, NEQ/LT).
//  Accepts a start request, loads x_i/y_i, iterates subtract-larger-from-smaller until the
//  operands are equal, then commits x to dReg. Reports done/error.
//  An iteration watchdog catches zero operands, which would otherwise never converge.
// PARAMETERS
//  ITER_W    4   width of the iteration counter
//  MAX_ITER  15  subtract steps allowed before abort; must be <= 2**ITER_W-1
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       asynchronous, active-low reset
//  start       in   1       request a GCD run; sampled only in IDLE
//  notEqual    in   1       datapath flag: xReg != yReg
//  lessThan    in   1       datapath flag: xReg < yReg
//  x_sel       out  1       xMux select: 0 = x_i, 1 = x-y
//  y_sel       out  1       yMux select: 0 = y_i, 1 = y-x
//  x_write     out  1       xReg enable
//  y_write     out  1       yReg enable
//  d_write     out  1       dReg enable (result commit)
//  busy        out  1       high from start acceptance until DONE/ERR is left
//  done        out  1       1-cycle pulse when the run ends (success or error)
//  error       out  1       held high from the ERR entry until the next accepted start
//  iter_count  out  ITER_W  subtract steps in the current/last run; held until next start
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; all outputs 0; iter_count=0.
//  States: IDLE, LOAD, RUN, DONE, ERR. The state register is the only sequential element
//  besides iter_count and error.
//  IDLE: if start, go LOAD; clear iter_count and error. Otherwise stay.
//  LOAD: x_sel=0, y_sel=0, x_write=1, y_write=1. Go RUN.
//  RUN: one datapath decision per cycle. Strobes are combinational (Mealy) from state and
//    flags. The flags are registered datapath outputs, so there is no combinational loop.
//    - !notEqual: d_write=1; go DONE.
//    - notEqual & lessThan: y_sel=1, y_write=1; iter_count++.
//    - notEqual & !lessThan: x_sel=1, x_write=1; iter_count++.
//    - notEqual & iter_count==MAX_ITER: no write strobes; go ERR. The check takes priority
//      over both subtract branches.
//  DONE: done=1 for one cycle, busy=1. Go IDLE.
//  ERR: done=1 and error=1 for one cycle; error stays held afterwards; d_write never
//    asserted, so dReg keeps its old value. Go IDLE.
//  busy=1 in LOAD, RUN, DONE and ERR. busy=0 in IDLE.
//  Latency: N subtract steps -> done is high in cycle N+3 after the start-sampling edge
//    (LOAD, N+1 RUN cycles, DONE).
//  Strobe rules:
//    - Exactly one of {x_write&y_write (LOAD), x_write, y_write, d_write, none} per cycle.
//    - When a write is 0, its sel is 0.
//  Boundaries:
//    - start held high: one run per IDLE visit; re-accepted only after returning to IDLE.
//    - start while busy: ignored, with no queuing.
//    - x_i==y_i: 0 steps; d_write in the first RUN cycle.
//    - Any operand 0 with the other nonzero: never converges -> ERR after MAX_ITER steps.
//    - Both operands 0: equal -> d_write with result 0, no error.
//    - iter_count saturates; it never wraps.
//    - reset mid-run: immediate IDLE and all strobes 0; datapath regs are reset by the
//      same signal.
// STRUCTURE
//  Shared package/header gcd_pkg: state encodings
//    IDLE=3'd0, LOAD=3'd1, RUN=3'd2, DONE=3'd3, ERR=3'd4
//  plus the MUX_SEL_INPUT=1'b0 / MUX_SEL_DIFF=1'b1 constants, shared with Datapath.
//  Single flat module: one state register block and one combinational next-state/output
//  block. No sub-module is needed.
//  A gcd_top wrapper (separate file) instantiates gcd_controller plus Datapath.
// TESTING (bench = gcd_controller + Datapath, x_i/y_i driven by the bench)
//  1. x=12, y=8, start pulse:
//     RUN does x_write (x=4), then y_write (y=4), then d_write.
//     d_o=4, iter_count=2, done at cycle 5, error=0.
//  2. x=15, y=1: 14 x-subtracts, d_o=1, iter_count=14, no error (MAX_ITER=15 boundary).
//  3. x=0, y=5: 15 y-writes with y unchanged, then ERR.
//     done=1 and error=1, dReg keeps its prior value, iter_count=15.
//  4. x=7, y=7: zero steps.
//     LOAD, then d_write in the first RUN cycle; done at cycle 3, d_o=7.
//  5. start held high across two runs (9,6 then 9,6):
//     two distinct done pulses, each d_o=3; a start pulse during RUN does not restart.
//  6. reset asserted in the 3rd RUN cycle of x=13, y=4:
//     outputs 0 asynchronously, state IDLE, d_o=0; a fresh start after release gives d_o=1.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the subtractive GCD block: controller state encoding
// and the operand-mux select values used by both controller and datapath.
package gcd_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } gcd_state_e;

    localparam logic MUX_SEL_INPUT = 1'b0;
    localparam logic MUX_SEL_DIFF  = 1'b1;

endpackage

// File: rtl/gcd_datapath.sv
// 4-bit subtractive GCD datapath: x/y operand registers, difference muxes,
// result register and the NEQ/LT flags derived from the registered operands.
module gcd_datapath
    import gcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic       x_sel,
    input  logic       y_sel,
    input  logic       x_write,
    input  logic       y_write,
    input  logic       d_write,
    output logic       notEqual,
    output logic       lessThan,
    output logic [3:0] d_o
);

    logic [3:0] x_reg;
    logic [3:0] y_reg;
    logic [3:0] x_next;
    logic [3:0] y_next;

    assign x_next = (x_sel == MUX_SEL_DIFF) ? x_reg - y_reg : x_i;
    assign y_next = (y_sel == MUX_SEL_DIFF) ? y_reg - x_reg : y_i;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values present before the clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_reg <= '0;
            y_reg <= '0;
            d_o   <= '0;
        end else begin
            if (x_write) x_reg <= x_next;
            if (y_write) y_reg <= y_next;
            if (d_write) d_o   <= x_reg;
        end
    end

    // Flags come straight from registers, so the controller's Mealy strobes
    // never close a combinational loop through the datapath.
    assign notEqual = (x_reg != y_reg);
    assign lessThan = (x_reg <  y_reg);

endmodule

// File: rtl/gcd_controller.sv
// Sequencer for the subtractive GCD datapath: load, iterate until equal,
// commit the result, with an iteration watchdog that aborts to an error state.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int ITER_W   = 4,
    parameter int MAX_ITER = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              notEqual,
    input  logic              lessThan,
    output logic              x_sel,
    output logic              y_sel,
    output logic              x_write,
    output logic              y_write,
    output logic              d_write,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ITER_W-1:0] iter_count
);

    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

    gcd_state_e state_q;
    gcd_state_e state_d;
    logic       iter_clr;
    logic       iter_inc;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        x_sel    = MUX_SEL_INPUT;
        y_sel    = MUX_SEL_INPUT;
        x_write  = 1'b0;
        y_write  = 1'b0;
        d_write  = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        iter_clr = 1'b0;
        iter_inc = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d  = LOAD;
                    iter_clr = 1'b1;
                end
            end
            LOAD: begin
                x_write = 1'b1;
                y_write = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (!notEqual) begin
                    d_write = 1'b1;
                    state_d = DONE;
                end else if (iter_count == ITER_LIMIT) begin
                    // Watchdog wins over both subtract branches.
                    state_d = ERR;
                end else if (lessThan) begin
                    y_sel    = MUX_SEL_DIFF;
                    y_write  = 1'b1;
                    iter_inc = 1'b1;
                end else begin
                    x_sel    = MUX_SEL_DIFF;
                    x_write  = 1'b1;
                    iter_inc = 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            iter_count <= '0;
            error      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (iter_clr) begin
                iter_count <= '0;
                error      <= 1'b0;
            end else begin
                if (iter_inc && iter_count != '1) iter_count <= iter_count + 1'b1;
                if (state_d == ERR) error <= 1'b1;
            end
        end
    end

endmodule
